// File: rtl/raider_join.sv
// raider_join: merges two 128-bit AXI4 slave halves of a striped transfer into one 256-bit master.
// AW/AR/W go through one-deep joined register slices; B/R are forked back to both halves.
module raider_join #(
  parameter int ADDR_WIDTH   = 48,
  parameter int S_DATA_WIDTH = 128,
  parameter int M_DATA_WIDTH = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  // slave 0 (low half)
  input  logic [ADDR_WIDTH-1:0]       s0_awaddr,
  input  logic [7:0]                  s0_awlen,
  input  logic [2:0]                  s0_awsize,
  input  logic [1:0]                  s0_awburst,
  input  logic                        s0_awvalid,
  output logic                        s0_awready,
  input  logic [S_DATA_WIDTH-1:0]     s0_wdata,
  input  logic [S_DATA_WIDTH/8-1:0]   s0_wstrb,
  input  logic                        s0_wlast,
  input  logic                        s0_wvalid,
  output logic                        s0_wready,
  output logic [1:0]                  s0_bresp,
  output logic                        s0_bvalid,
  input  logic                        s0_bready,
  input  logic [ADDR_WIDTH-1:0]       s0_araddr,
  input  logic [7:0]                  s0_arlen,
  input  logic [2:0]                  s0_arsize,
  input  logic [1:0]                  s0_arburst,
  input  logic                        s0_arvalid,
  output logic                        s0_arready,
  output logic [S_DATA_WIDTH-1:0]     s0_rdata,
  output logic [1:0]                  s0_rresp,
  output logic                        s0_rlast,
  output logic                        s0_rvalid,
  input  logic                        s0_rready,
  // slave 1 (high half)
  input  logic [ADDR_WIDTH-1:0]       s1_awaddr,
  input  logic [7:0]                  s1_awlen,
  input  logic [2:0]                  s1_awsize,
  input  logic [1:0]                  s1_awburst,
  input  logic                        s1_awvalid,
  output logic                        s1_awready,
  input  logic [S_DATA_WIDTH-1:0]     s1_wdata,
  input  logic [S_DATA_WIDTH/8-1:0]   s1_wstrb,
  input  logic                        s1_wlast,
  input  logic                        s1_wvalid,
  output logic                        s1_wready,
  output logic [1:0]                  s1_bresp,
  output logic                        s1_bvalid,
  input  logic                        s1_bready,
  input  logic [ADDR_WIDTH-1:0]       s1_araddr,
  input  logic [7:0]                  s1_arlen,
  input  logic [2:0]                  s1_arsize,
  input  logic [1:0]                  s1_arburst,
  input  logic                        s1_arvalid,
  output logic                        s1_arready,
  output logic [S_DATA_WIDTH-1:0]     s1_rdata,
  output logic [1:0]                  s1_rresp,
  output logic                        s1_rlast,
  output logic                        s1_rvalid,
  input  logic                        s1_rready,
  // master
  output logic [ADDR_WIDTH-1:0]       m_awaddr,
  output logic [7:0]                  m_awlen,
  output logic [2:0]                  m_awsize,
  output logic [1:0]                  m_awburst,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [M_DATA_WIDTH-1:0]     m_wdata,
  output logic [M_DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                        m_wlast,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic [1:0]                  m_bresp,
  input  logic                        m_bvalid,
  output logic                        m_bready,
  output logic [ADDR_WIDTH-1:0]       m_araddr,
  output logic [7:0]                  m_arlen,
  output logic [2:0]                  m_arsize,
  output logic [1:0]                  m_arburst,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [M_DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  output logic [2:0]                  err
);

  if (M_DATA_WIDTH != 2 * S_DATA_WIDTH) begin : g_width_check
    $error("raider_join: M_DATA_WIDTH must equal 2*S_DATA_WIDTH");
  end

  // ---------------- AW join slice ----------------
  logic                  aw_valid_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [7:0]            aw_len_q;
  logic [2:0]            aw_size_q;
  logic [1:0]            aw_burst_q;
  logic                  aw_fire, aw_mismatch;

  assign aw_fire     = s0_awvalid & s1_awvalid & (~aw_valid_q | m_awready);
  assign s0_awready  = aw_fire;
  assign s1_awready  = aw_fire;
  assign aw_mismatch = (s0_awaddr != s1_awaddr) | (s0_awlen != s1_awlen) |
                       (s0_awsize != s1_awsize) | (s0_awburst != s1_awburst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
    end else if (aw_fire) begin
      aw_valid_q <= 1'b1;
      aw_addr_q  <= s0_awaddr;
      aw_len_q   <= s0_awlen;
      aw_size_q  <= s0_awsize;
      aw_burst_q <= s0_awburst;
    end else if (m_awready) begin
      aw_valid_q <= 1'b0;
    end
  end

  assign m_awvalid = aw_valid_q;
  assign m_awaddr  = aw_addr_q;
  assign m_awlen   = aw_len_q;
  assign m_awsize  = aw_size_q;
  assign m_awburst = aw_burst_q;

  // ---------------- AR join slice ----------------
  logic                  ar_valid_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]            ar_len_q;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q;
  logic                  ar_fire, ar_mismatch;

  assign ar_fire     = s0_arvalid & s1_arvalid & (~ar_valid_q | m_arready);
  assign s0_arready  = ar_fire;
  assign s1_arready  = ar_fire;
  assign ar_mismatch = (s0_araddr != s1_araddr) | (s0_arlen != s1_arlen) |
                       (s0_arsize != s1_arsize) | (s0_arburst != s1_arburst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
    end else if (ar_fire) begin
      ar_valid_q <= 1'b1;
      ar_addr_q  <= s0_araddr;
      ar_len_q   <= s0_arlen;
      ar_size_q  <= s0_arsize;
      ar_burst_q <= s0_arburst;
    end else if (m_arready) begin
      ar_valid_q <= 1'b0;
    end
  end

  assign m_arvalid = ar_valid_q;
  assign m_araddr  = ar_addr_q;
  assign m_arlen   = ar_len_q;
  assign m_arsize  = ar_size_q;
  assign m_arburst = ar_burst_q;

  // ---------------- W join slice ----------------
  logic                      w_valid_q;
  logic [M_DATA_WIDTH-1:0]   w_data_q;
  logic [M_DATA_WIDTH/8-1:0] w_strb_q;
  logic                      w_last_q;
  logic                      w_fire;

  assign w_fire    = s0_wvalid & s1_wvalid & (~w_valid_q | m_wready);
  assign s0_wready = w_fire;
  assign s1_wready = w_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_last_q  <= 1'b0;
    end else if (w_fire) begin
      w_valid_q <= 1'b1;
      w_data_q  <= {s1_wdata, s0_wdata};
      w_strb_q  <= {s1_wstrb, s0_wstrb};
      w_last_q  <= s0_wlast;
    end else if (m_wready) begin
      w_valid_q <= 1'b0;
    end
  end

  assign m_wvalid = w_valid_q;
  assign m_wdata  = w_data_q;
  assign m_wstrb  = w_strb_q;
  assign m_wlast  = w_last_q;

  // ---------------- sticky mismatch flags ----------------
  logic [2:0] err_q, err_d;

  assign err_d = err_q | {w_fire & (s0_wlast != s1_wlast), ar_fire & ar_mismatch,
                          aw_fire & aw_mismatch};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err = err_q;

  // ---------------- B fork ----------------
  // done bit marks a branch that already took the current master beat
  logic [1:0] b_done_q, b_done_d;

  assign s0_bvalid = m_bvalid & ~b_done_q[0];
  assign s1_bvalid = m_bvalid & ~b_done_q[1];
  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;
  assign m_bready  = (s0_bready | b_done_q[0]) & (s1_bready | b_done_q[1]);
  assign b_done_d  = {2{m_bvalid & ~m_bready}} & (b_done_q | {s1_bready, s0_bready});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) b_done_q <= '0;
    else     b_done_q <= b_done_d;
  end

  // ---------------- R fork ----------------
  logic [1:0] r_done_q, r_done_d;

  assign s0_rvalid = m_rvalid & ~r_done_q[0];
  assign s1_rvalid = m_rvalid & ~r_done_q[1];
  assign s0_rdata  = m_rdata[S_DATA_WIDTH-1:0];
  assign s1_rdata  = m_rdata[M_DATA_WIDTH-1:S_DATA_WIDTH];
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign m_rready  = (s0_rready | r_done_q[0]) & (s1_rready | r_done_q[1]);
  assign r_done_d  = {2{m_rvalid & ~m_rready}} & (r_done_q | {s1_rready, s0_rready});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_done_q <= '0;
    else     r_done_q <= r_done_d;
  end

endmodule

// File: tb/tb_raider_join.sv
// Self-checking bench for raider_join: vector tables, directed corner sequences and
// randomized W/R traffic against a queue-based reference model.
module tb_raider_join;
  localparam int A  = 48;
  localparam int S  = 128;
  localparam int M  = 256;
  localparam int SB = S / 8;
  localparam int MB = M / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [A-1:0]  s0_awaddr, s1_awaddr, m_awaddr, s0_araddr, s1_araddr, m_araddr;
  logic [7:0]    s0_awlen, s1_awlen, m_awlen, s0_arlen, s1_arlen, m_arlen;
  logic [2:0]    s0_awsize, s1_awsize, m_awsize, s0_arsize, s1_arsize, m_arsize;
  logic [1:0]    s0_awburst, s1_awburst, m_awburst, s0_arburst, s1_arburst, m_arburst;
  logic          s0_awvalid, s1_awvalid, m_awvalid, s0_awready, s1_awready, m_awready;
  logic          s0_arvalid, s1_arvalid, m_arvalid, s0_arready, s1_arready, m_arready;
  logic [S-1:0]  s0_wdata, s1_wdata, s0_rdata, s1_rdata;
  logic [SB-1:0] s0_wstrb, s1_wstrb;
  logic          s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
  logic [1:0]    s0_bresp, s1_bresp, m_bresp, s0_rresp, s1_rresp, m_rresp;
  logic          s0_bvalid, s1_bvalid, m_bvalid, s0_bready, s1_bready, m_bready;
  logic          s0_rlast, s1_rlast, m_rlast, s0_rvalid, s1_rvalid, m_rvalid;
  logic          s0_rready, s1_rready, m_rready;
  logic [M-1:0]  m_wdata, m_rdata;
  logic [MB-1:0] m_wstrb;
  logic          m_wlast, m_wvalid, m_wready;
  logic [2:0]    err;

  raider_join #(.ADDR_WIDTH(A), .S_DATA_WIDTH(S), .M_DATA_WIDTH(M)) dut (
    .clk(clk), .rst(rst),
    .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize), .s0_awburst(s0_awburst),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid),
    .s0_wready(s0_wready), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid),
    .s0_rready(s0_rready),
    .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid),
    .s1_wready(s1_wready), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid),
    .s1_rready(s1_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    s0_awaddr = '0; s0_awlen = '0; s0_awsize = '0; s0_awburst = '0; s0_awvalid = 1'b0;
    s1_awaddr = '0; s1_awlen = '0; s1_awsize = '0; s1_awburst = '0; s1_awvalid = 1'b0;
    s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0; s0_arvalid = 1'b0;
    s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0; s1_arvalid = 1'b0;
    s0_wdata = '0; s0_wstrb = '0; s0_wlast = 1'b0; s0_wvalid = 1'b0;
    s1_wdata = '0; s1_wstrb = '0; s1_wlast = 1'b0; s1_wvalid = 1'b0;
    s0_bready = 1'b0; s1_bready = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
    m_awready = 1'b0; m_arready = 1'b0; m_wready = 1'b0;
    m_bresp = '0; m_bvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  // ---- reference model: W slice as a queue of joined beats, R fork as per-branch taken flags
  typedef struct { logic [M-1:0] data; logic [MB-1:0] strb; logic last; } w_beat_t;
  w_beat_t    wq[$];
  int         w_delivered;
  logic [2:0] exp_err;
  logic [1:0] r_taken;
  int         r_got0, r_got1;

  task automatic w_cycle(input logic v0, input logic v1, input logic mr,
                         input logic [S-1:0] d0, input logic [S-1:0] d1,
                         input logic [SB-1:0] st0, input logic [SB-1:0] st1,
                         input logic l0, input logic l1, output logic took);
    logic    exp_rdy;
    w_beat_t nb;
    next_cycle();
    s0_wvalid = v0; s1_wvalid = v1; m_wready = mr;
    s0_wdata = d0; s1_wdata = d1; s0_wstrb = st0; s1_wstrb = st1; s0_wlast = l0; s1_wlast = l1;
    settle();
    exp_rdy = v0 & v1 & ((wq.size() == 0) | mr);
    chk("w_s0_ready", M'(s0_wready), M'(exp_rdy));
    chk("w_s1_ready", M'(s1_wready), M'(exp_rdy));
    chk("w_m_valid", M'(m_wvalid), M'(wq.size() != 0));
    if (wq.size() != 0) begin
      chk("w_m_data", m_wdata, wq[0].data);
      chk("w_m_strb", M'(m_wstrb), M'(wq[0].strb));
      chk("w_m_last", M'(m_wlast), M'(wq[0].last));
    end
    chk("w_err", M'(err), M'(exp_err));
    if (wq.size() != 0 && mr) begin
      void'(wq.pop_front());
      w_delivered++;
    end
    if (exp_rdy) begin
      nb.data = {d1, d0};
      nb.strb = {st1, st0};
      nb.last = l0;
      wq.push_back(nb);
      if (l0 != l1) exp_err[2] = 1'b1;
    end
    took = exp_rdy;
  endtask

  task automatic r_cycle(input logic mv, input logic r0, input logic r1,
                         input logic [M-1:0] d, input logic last, output logic done);
    logic ev0, ev1, emr;
    next_cycle();
    m_rvalid = mv; m_rdata = d; m_rlast = last; m_rresp = d[1:0];
    s0_rready = r0; s1_rready = r1;
    settle();
    ev0 = mv & ~r_taken[0];
    ev1 = mv & ~r_taken[1];
    emr = (r0 | r_taken[0]) & (r1 | r_taken[1]);
    chk("r_s0_valid", M'(s0_rvalid), M'(ev0));
    chk("r_s1_valid", M'(s1_rvalid), M'(ev1));
    chk("r_m_ready", M'(m_rready), M'(emr));
    if (ev0) begin
      chk("r_s0_data", M'(s0_rdata), M'(d[S-1:0]));
      chk("r_s0_resp_last", M'({s0_rresp, s0_rlast}), M'({d[1:0], last}));
    end
    if (ev1) begin
      chk("r_s1_data", M'(s1_rdata), M'(d[M-1:S]));
      chk("r_s1_resp_last", M'({s1_rresp, s1_rlast}), M'({d[1:0], last}));
    end
    if (s0_rvalid & r0) r_got0++;
    if (s1_rvalid & r1) r_got1++;
    done = mv & emr;
    if (done) begin
      chk("r_once_s0", M'(r_got0), M'(1));
      chk("r_once_s1", M'(r_got1), M'(1));
      r_got0 = 0; r_got1 = 0; r_taken = '0;
    end else if (mv) begin
      r_taken = r_taken | {ev1 & r1, ev0 & r0};
    end else begin
      r_taken = '0;
    end
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    wq.delete(); exp_err = '0; r_taken = '0; r_got0 = 0; r_got1 = 0;
    settle();
    chk("rst_valids", M'({m_awvalid, m_wvalid, m_arvalid}), M'(3'b000));
    chk("rst_err", M'(err), M'(3'b000));
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  typedef struct { logic v0; logic v1; logic mr; logic exp_rdy; logic exp_mv; } join_vec_t;
  typedef struct { logic mv; logic r0; logic r1; logic ev0; logic ev1; logic emr; } fork_vec_t;

  initial begin
    join_vec_t    jv[6];
    fork_vec_t    fv[6];
    logic         took, done, presenting, mv, r0, r1, rl, l0, v0, v1, mr;
    logic [M-1:0] rd;
    logic [S-1:0] da, db;
    int           idx;

    jv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    jv[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    jv[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    jv[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    jv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    jv[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    fv[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    fv[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    fv[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    fv[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    fv[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    fv[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    idle_inputs();
    wq.delete(); exp_err = '0; r_taken = '0; r_got0 = 0; r_got1 = 0; w_delivered = 0;
    #1;
    chk("init_valids", M'({m_awvalid, m_wvalid, m_arvalid}), M'(3'b000));
    chk("init_err", M'(err), M'(3'b000));
    do_reset();

    // AW join table, slice empty before each vector
    foreach (jv[i]) begin
      next_cycle();
      s0_awvalid = jv[i].v0; s1_awvalid = jv[i].v1; m_awready = jv[i].mr;
      s0_awaddr = A'(48'h100 * (i + 1)); s1_awaddr = A'(48'h100 * (i + 1));
      settle();
      chk($sformatf("jv%0d_s0_awready", i), M'(s0_awready), M'(jv[i].exp_rdy));
      chk($sformatf("jv%0d_s1_awready", i), M'(s1_awready), M'(jv[i].exp_rdy));
      next_cycle();
      s0_awvalid = 1'b0; s1_awvalid = 1'b0; m_awready = 1'b0;
      settle();
      chk($sformatf("jv%0d_m_awvalid", i), M'(m_awvalid), M'(jv[i].exp_mv));
      if (jv[i].exp_mv) chk($sformatf("jv%0d_m_awaddr", i), M'(m_awaddr), M'(48'h100 * (i + 1)));
      next_cycle();
      m_awready = 1'b1;
      next_cycle();
      m_awready = 1'b0;
    end

    // B fork table, flags cleared by an idle cycle after each vector
    foreach (fv[i]) begin
      next_cycle();
      m_bvalid = fv[i].mv; s0_bready = fv[i].r0; s1_bready = fv[i].r1; m_bresp = 2'(i);
      settle();
      chk($sformatf("fv%0d_s0_bvalid", i), M'(s0_bvalid), M'(fv[i].ev0));
      chk($sformatf("fv%0d_s1_bvalid", i), M'(s1_bvalid), M'(fv[i].ev1));
      chk($sformatf("fv%0d_m_bready", i), M'(m_bready), M'(fv[i].emr));
      chk($sformatf("fv%0d_bresp", i), M'({s1_bresp, s0_bresp}), M'({2'(i), 2'(i)}));
      next_cycle();
      m_bvalid = 1'b0; s0_bready = 1'b0; s1_bready = 1'b0;
    end

    // AW skew: s1 arrives two cycles after s0
    next_cycle();
    s0_awaddr = A'(48'h1000); s0_awlen = 8'd3; s0_awsize = 3'd4; s0_awburst = 2'd1;
    s0_awvalid = 1'b1;
    settle();
    chk("skew_c0_ready", M'({s0_awready, s1_awready}), M'(2'b00));
    next_cycle();
    settle();
    chk("skew_c1_ready", M'({s0_awready, s1_awready}), M'(2'b00));
    next_cycle();
    s1_awaddr = A'(48'h1000); s1_awlen = 8'd3; s1_awsize = 3'd4; s1_awburst = 2'd1;
    s1_awvalid = 1'b1;
    settle();
    chk("skew_c2_ready", M'({s0_awready, s1_awready}), M'(2'b11));
    chk("skew_c2_mvalid", M'(m_awvalid), M'(1'b0));
    next_cycle();
    s0_awaddr = A'(48'h1100); s1_awaddr = A'(48'h1100);
    settle();
    chk("skew_c3_mvalid", M'(m_awvalid), M'(1'b1));
    chk("skew_c3_addr_len", M'({m_awaddr, m_awlen}), M'({48'h1000, 8'd3}));
    chk("skew_c3_full_ready", M'({s0_awready, s1_awready}), M'(2'b00));
    chk("skew_c3_err", M'(err), M'(3'b000));
    next_cycle();
    m_awready = 1'b1;
    settle();
    chk("skew_c4_ready", M'({s0_awready, s1_awready}), M'(2'b11));
    chk("skew_c4_addr", M'(m_awaddr), M'(48'h1000));
    next_cycle();
    s0_awvalid = 1'b0; s1_awvalid = 1'b0;
    settle();
    chk("skew_c5_addr", M'({m_awvalid, m_awaddr}), M'({1'b1, 48'h1100}));
    next_cycle();
    settle();
    chk("skew_c6_mvalid", M'(m_awvalid), M'(1'b0));
    m_awready = 1'b0;

    // W burst at full throughput
    w_delivered = 0;
    for (int i = 0; i < 6; i++) begin
      w_cycle(i < 4, i < 4, 1'b1, S'(32'hAA00 + i), S'(32'hBB00 + i), '1, SB'(16'h0F0F),
              i == 3, i == 3, took);
    end
    chk("wburst_beats", M'(w_delivered), M'(4));

    // W burst with master stall in cycles 2-4
    w_delivered = 0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      v0 = idx < 4;
      w_cycle(v0, v0, !(c >= 2 && c <= 4), S'(32'hCA00 + idx), S'(32'hCB00 + idx), '1, '1,
              idx == 3, idx == 3, took);
      if (took) idx++;
    end
    chk("wbp_sent", M'(idx), M'(4));
    chk("wbp_delivered", M'(w_delivered), M'(4));

    // R fork: s1 lags two cycles on the first beat
    rd = {{4{32'hB0B0_B0B0}}, {4{32'hA0A0_A0A0}}};
    r_cycle(1'b1, 1'b1, 1'b0, rd, 1'b0, done);
    chk("rfork_c0_done", M'(done), M'(1'b0));
    r_cycle(1'b1, 1'b1, 1'b0, rd, 1'b0, done);
    chk("rfork_c1_done", M'(done), M'(1'b0));
    r_cycle(1'b1, 1'b0, 1'b1, rd, 1'b0, done);
    chk("rfork_c2_done", M'(done), M'(1'b1));
    rd = {{4{32'hB1B1_B1B1}}, {4{32'hA1A1_A1A1}}};
    r_cycle(1'b1, 1'b1, 1'b1, rd, 1'b1, done);
    chk("rfork_c3_done", M'(done), M'(1'b1));

    // randomized R traffic; a master beat is held until the fork accepts it
    presenting = 1'b0;
    mv = 1'b0; rl = 1'b0; rd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!presenting) begin
        mv = ($urandom % 3) != 0;
        rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        rl = 1'($urandom % 2);
      end
      r0 = 1'($urandom % 2);
      r1 = 1'($urandom % 2);
      r_cycle(mv, r0, r1, rd, rl, done);
      presenting = mv & ~done;
    end
    r_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, done);

    // randomized W traffic, including occasional wlast disagreement
    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom % 4) != 0;
      v1 = ($urandom % 4) != 0;
      mr = ($urandom % 3) != 0;
      da = {$urandom, $urandom, $urandom, $urandom};
      db = {$urandom, $urandom, $urandom, $urandom};
      l0 = 1'($urandom % 2);
      w_cycle(v0, v1, mr, da, db, SB'($urandom), SB'($urandom), l0,
              (($urandom % 16) == 0) ? ~l0 : l0, took);
    end
    do_reset();

    // AR address mismatch: forwarded from s0, err[1] sticky until reset
    next_cycle();
    s0_araddr = A'(48'h2000); s1_araddr = A'(48'h2040);
    s0_arlen = 8'd1; s1_arlen = 8'd1; s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    settle();
    chk("armis_ready", M'({s0_arready, s1_arready}), M'(2'b11));
    chk("armis_err_before", M'(err), M'(3'b000));
    next_cycle();
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_arready = 1'b1;
    settle();
    chk("armis_fwd", M'({m_arvalid, m_araddr, m_arlen}), M'({1'b1, 48'h2000, 8'd1}));
    chk("armis_err", M'(err), M'(3'b010));
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      settle();
      chk("armis_err_hold", M'(err), M'(3'b010));
    end
    m_arready = 1'b0;

    // reset while W beat is held and B branch 0 is already done
    next_cycle();
    s0_wvalid = 1'b1; s1_wvalid = 1'b1; s0_wdata = S'(32'hDEAD); s1_wdata = S'(32'hBEEF);
    m_wready = 1'b0; m_bvalid = 1'b1; s0_bready = 1'b1; s1_bready = 1'b0;
    settle();
    chk("rmb_bready_pre", M'(m_bready), M'(1'b0));
    next_cycle();
    s0_wvalid = 1'b0; s1_wvalid = 1'b0;
    settle();
    chk("rmb_wvalid_held", M'(m_wvalid), M'(1'b1));
    chk("rmb_bvalid_split", M'({s1_bvalid, s0_bvalid}), M'(2'b10));
    #2;
    rst = 1'b1;
    #1;
    chk("rmb_wvalid_rst", M'(m_wvalid), M'(1'b0));
    chk("rmb_bvalid_rst", M'({s1_bvalid, s0_bvalid}), M'(2'b11));
    chk("rmb_err_rst", M'(err), M'(3'b000));
    next_cycle();
    rst = 1'b0;
    s1_bready = 1'b1;
    wq.delete(); exp_err = '0;
    settle();
    chk("rmb_bready_clean", M'(m_bready), M'(1'b1));
    next_cycle();
    m_bvalid = 1'b0; s0_bready = 1'b0; s1_bready = 1'b0;
    settle();
    chk("rmb_wvalid_idle", M'(m_wvalid), M'(1'b0));
    w_delivered = 0;
    for (int i = 0; i < 6; i++) begin
      w_cycle(i < 4, i < 4, 1'b1, S'(32'hEA00 + i), S'(32'hEB00 + i), '1, '1,
              i == 3, i == 3, took);
    end
    chk("rmb_new_burst", M'(w_delivered), M'(4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
